// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit-counter width; clamped to 1 so tiny WIDTH values still give a legal vector.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result bus of the bit-serial adder.
// The ovf signal exists only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;

  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/serial_adder_full_adder_bit.sv
// Purely combinational one-bit full adder cell.
module full_adder_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  output logic s_o,
  output logic cout_o
);
  assign s_o    = a_i ^ b_i ^ cin_i;
  assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell, LSB first, one bit per clock.
// Optional signed overflow output is enabled by SERIAL_ADDER_OVF_EN.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);

  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic fa_s;
  logic fa_co;

  full_adder_bit u_fa (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .s_o    (fa_s),
    .cout_o (fa_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next state and datapath; results only move on the RUN->DONE edge.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          cnt_d   = '0;
          res_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        carry_d = fa_co;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        if (cnt_q == LAST_CNT) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q is the carry into the MSB at this point
          ovf_d   = carry_q ^ fa_co;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ovf(input string tag, input logic exp);
`ifdef SERIAL_ADDER_OVF_EN
    check(tag, 32'(bus.ovf), 32'(exp));
`else
    if (exp === 1'bx) $display("unreachable %s", tag);
`endif
  endtask

  // Issue one operation; returns at the sample point where done is seen (or timeout).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic c,
                        input int pulse_at, output int lat, output int bcnt);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.cin   = c;
    @(negedge clk);
    bus.start = 1'b0;
    lat  = 0;
    bcnt = 0;
    while (!bus.done && lat < 20) begin
      if (bus.busy) bcnt++;
      if (lat == pulse_at) begin
        bus.start = 1'b1;
        bus.a     = 8'h11;
        bus.b     = 8'h22;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
  endtask

  int   lat;
  int   bcnt;
  int   nd;
  int   n;
  logic stable;
  logic fb;
  logic fd;

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum",  32'(bus.sum),  32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    check_ovf("rst_ovf", 1'b0);
    rst_n = 1'b1;

    // 0x0F + 0x01
    run_op(8'h0F, 8'h01, 1'b0, -1, lat, bcnt);
    check("t1_latency", 32'(lat), 32'd8);
    check("t1_busy_cycles", 32'(bcnt), 32'd8);
    check("t1_busy_at_done", 32'(bus.busy), 32'd0);
    check("t1_sum", 32'(bus.sum), 32'h10);
    check("t1_cout", 32'(bus.cout), 32'd0);
    check_ovf("t1_ovf", 1'b0);
    @(negedge clk);
    check("t1_done_one_cycle", 32'(bus.done), 32'd0);
    check("t1_sum_held", 32'(bus.sum), 32'h10);

    // 0xFF + 0x01 and 0xFF + 0x00 + cin
    run_op(8'hFF, 8'h01, 1'b0, -1, lat, bcnt);
    check("t2a_sum", 32'(bus.sum), 32'h00);
    check("t2a_cout", 32'(bus.cout), 32'd1);
    check_ovf("t2a_ovf", 1'b0);
    run_op(8'hFF, 8'h00, 1'b1, -1, lat, bcnt);
    check("t2b_sum", 32'(bus.sum), 32'h00);
    check("t2b_cout", 32'(bus.cout), 32'd1);
    check_ovf("t2b_ovf", 1'b0);

    // signed overflow cases
    run_op(8'h7F, 8'h01, 1'b0, -1, lat, bcnt);
    check("t3a_sum", 32'(bus.sum), 32'h80);
    check("t3a_cout", 32'(bus.cout), 32'd0);
    check_ovf("t3a_ovf", 1'b1);
    run_op(8'h80, 8'h80, 1'b0, -1, lat, bcnt);
    check("t3b_sum", 32'(bus.sum), 32'h00);
    check("t3b_cout", 32'(bus.cout), 32'd1);
    check_ovf("t3b_ovf", 1'b1);

    // start during RUN is ignored
    run_op(8'h05, 8'h03, 1'b0, 3, lat, bcnt);
    check("t4_latency", 32'(lat), 32'd8);
    check("t4_sum", 32'(bus.sum), 32'h08);
    check("t4_cout", 32'(bus.cout), 32'd0);
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("t4_extra_done", 32'(nd), 32'd0);

    // back-to-back start during DONE
    run_op(8'h05, 8'h03, 1'b0, -1, lat, bcnt);
    check("t5_first_sum", 32'(bus.sum), 32'h08);
    bus.start = 1'b1;
    bus.a     = 8'h10;
    bus.b     = 8'h20;
    bus.cin   = 1'b0;
    n = 0;
    stable = 1'b1;
    fb = 1'b0;
    fd = 1'b1;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.start = 1'b0;
        fb = bus.busy;
        fd = bus.done;
      end
      if (!bus.done && bus.sum !== 8'h08) stable = 1'b0;
    end while (!bus.done && n < 20);
    check("t5_b2b_spacing", 32'(n), 32'd9);
    check("t5_busy_rises", 32'(fb), 32'd1);
    check("t5_done_falls", 32'(fd), 32'd0);
    check("t5_sum_stable", 32'(stable), 32'd1);
    check("t5_second_sum", 32'(bus.sum), 32'h30);
    check("t5_second_cout", 32'(bus.cout), 32'd0);

    // reset in the middle of 0xAA + 0x55 (bit 4)
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 8'hAA;
    bus.b     = 8'h55;
    bus.cin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_rst_busy", 32'(bus.busy), 32'd0);
    check("t6_rst_done", 32'(bus.done), 32'd0);
    check("t6_rst_sum", 32'(bus.sum), 32'd0);
    check("t6_rst_cout", 32'(bus.cout), 32'd0);
    check("t6_rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    check_ovf("t6_rst_ovf", 1'b0);
    rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    check("t6_no_done", 32'(nd), 32'd0);
    run_op(8'hAA, 8'h55, 1'b0, -1, lat, bcnt);
    check("t6_latency", 32'(lat), 32'd8);
    check("t6_sum", 32'(bus.sum), 32'hFF);
    check("t6_cout", 32'(bus.cout), 32'd0);
    check_ovf("t6_ovf", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder computing `a + b + cin` one bit per clock, LSB first, through a single full-adder cell and a carry flip-flop. It is the additive counterpart of the team's full subtractor, intended as the area-minimal arithmetic unit behind slow control paths. Operands are loaded on a start pulse, and the result is presented with a one-cycle `done` strobe and held until the next operation.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal values ≥ 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE or DONE.
- `a`  in  WIDTH  augend; captured on the accepting edge.
- `b`  in  WIDTH  addend; captured on the accepting edge.
- `cin`  in  1  carry-in; captured on the accepting edge.
- `busy`  out  1  high while bits are being processed (RUN).
- `done`  out  1  single-cycle strobe; result valid.
- `sum`  out  WIDTH  result; held from `done` until the next `done`.
- `cout`  out  1  carry out of bit WIDTH-1; held with `sum`.
- `ovf`  out  1  signed overflow; present only with the macro (see Configuration).

## Operation
- States: IDLE, RUN, DONE.
  - IDLE → RUN: `start`=1.
  - RUN → DONE: last bit processed.
  - DONE → RUN: `start`=1.
  - DONE → IDLE: `start`=0.
- Accept (IDLE or DONE with `start`=1):
  - Load shift registers A and B with `a` and `b`.
  - Load the carry FF with `cin`.
  - Clear the bit counter to 0 and the result shift register to 0.
- RUN, each edge:
  - s = A[0]^B[0]^c.
  - Carry FF ← A[0]&B[0] | c&(A[0]^B[0]).
  - A and B shift right by one.
  - Result shift register shifts right, with s inserted at bit WIDTH-1.
  - Counter increments.
- The bit counter is $clog2(WIDTH) bits wide. RUN ends on the edge where counter == WIDTH-1. The counter does not wrap.
- On the RUN→DONE edge:
  - `sum` ← final result shift register, including the last bit.
  - `cout` ← final carry.
- `sum` and `cout` change only on the RUN→DONE edge, so they stay stable while the next operation runs.
- `start` in RUN is ignored. There is no queuing, and operands are not re-captured.
- Reset (`rst_n`=0 at any edge, including mid-RUN):
  - State → IDLE.
  - `busy`=0, `done`=0, `sum`=0, `cout`=0, `ovf`=0.
  - Counter, carry FF, and all shift registers → 0.
  - The in-flight operation is discarded, with no `done`.

## Timing
- Accepting edge E0. After E0: `busy`=1.
- Edges E1..EWIDTH process bits 0..WIDTH-1.
- After EWIDTH: `busy`=0, `done`=1, `sum`/`cout` valid.
- Latency from accepting edge to `done` high: WIDTH cycles. `busy` is high for exactly WIDTH cycles.
- `done` is high for exactly one cycle.
- Back-to-back: `start`=1 during the DONE cycle is accepted on that edge. `busy` rises the same edge `done` falls. Throughput is one result per WIDTH+1 cycles.
- `busy` and `done` are never high simultaneously.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- `SERIAL_ADDER_OVF_EN`: signed overflow detection.
- Defined:
  - The `ovf` port exists.
  - On the RUN→DONE edge, `ovf` ← (carry into MSB) ^ (carry out of MSB). This equals a[W-1]==b[W-1] && sum[W-1]!=a[W-1] (with `cin` included).
  - `ovf` is held with `sum` and reset to 0.
- Undefined:
  - The `ovf` port and its logic are absent.
  - All other behaviour is identical.

## Structure
- `serial_adder_pkg`:
  - State enum typedef (ST_IDLE, ST_RUN, ST_DONE).
  - Counter width helper (`$clog2`-based constant function).
- Sub-module `full_adder_bit`: purely combinational 1-bit (a, b, cin) → (s, cout), instantiated once in the datapath.
- FSM, counter, shift registers, and output registers live in `serial_adder`.

## Test plan
- WIDTH=8, a=0x0F, b=0x01, cin=0 → `done` exactly 8 cycles after acceptance; `sum`=0x10, `cout`=0, `ovf`=0; `busy` high 8 cycles.
- a=0xFF, b=0x01, cin=0 → `sum`=0x00, `cout`=1, `ovf`=0. Then a=0xFF, b=0x00, cin=1 → `sum`=0x00, `cout`=1.
- a=0x7F, b=0x01, cin=0 → `sum`=0x80, `cout`=0, `ovf`=1 (macro on). a=0x80, b=0x80 → `sum`=0x00, `cout`=1, `ovf`=1.
- `start` pulsed with new operands (0x11, 0x22) during RUN of 0x05+0x03 → ignored; `sum`=0x08; only one `done`.
- `start` held during the DONE cycle with 0x10+0x20 → the new operation starts with no idle cycle; second `done` 9 cycles after the first with `sum`=0x30. First `sum`=0x08 stays stable until then.
- `rst_n`=0 for one edge at bit 4 of 0xAA+0x55 → all outputs 0, IDLE, no `done`. A following 0xAA+0x55 → `sum`=0xFF, `cout`=0.
